// File: rtl/ft_tx_arb_if.sv
// Source-FIFO and TX-stream signal bundle for the FT601Q TX burst arbiter.
interface ft_tx_arb_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]    src_avail;
  logic [N_CH-1:0]    src_empty;
  logic [32*N_CH-1:0] src_data;
  logic [N_CH-1:0]    src_rd_en;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               out_last;
  logic               out_ready;

  modport master (
    input  src_avail, src_empty, src_data, out_ready,
    output src_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output src_avail, src_empty, src_data, out_ready,
    input  src_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ft_tx_arb.sv
// Round-robin burst arbiter/packetiser: one header word plus BURST_WORDS-1 payload words per grant.
//   state | meaning
//   IDLE  | waiting for enable and an available source; picks next channel round-robin
//   HDR   | presenting header word {SYNC, chan, 4'h0, seq}
//   DATA  | streaming payload from the granted source FIFO
module ft_tx_arb #(
  parameter int         N_CH        = 4,
  parameter int         BURST_WORDS = 1024,
  parameter logic [7:0] SYNC        = 8'hA5,
  localparam int        CW          = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int        WW          = $clog2(BURST_WORDS)
) (
  input  logic          ft_clk,
  input  logic          nrst,
  input  logic          enable,
  ft_tx_arb_if.master   bus,
  output logic          busy,
  output logic [CW-1:0] cur_chan,
  output logic [15:0]   seq
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] last_grant;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] pick, idx;
  logic          found;
  logic          hs;

  always_ff @(posedge ft_clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cur_chan   <= '0;
      last_grant <= CW'(N_CH - 1);
      wcnt       <= '0;
      seq        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && enable && found)
        cur_chan <= pick;
      if (state == HDR && bus.out_ready)
        wcnt <= '0;
      if (state == DATA && hs) begin
        wcnt <= wcnt + 1'b1;
        if (bus.out_last) begin
          last_grant <= cur_chan;
          seq        <= seq + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    found         = 1'b0;
    pick          = '0;
    idx           = '0;
    hs            = 1'b0;
    bus.src_rd_en = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;

    // first available channel strictly after the previous grant, wrapping
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(last_grant) + i) % N_CH);
      if (!found && bus.src_avail[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state)
      IDLE: begin
        if (enable && found)
          state_nxt = HDR;
      end
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {SYNC, 4'(cur_chan), 4'h0, seq};
        if (bus.out_ready)
          state_nxt = DATA;
      end
      DATA: begin
        bus.out_valid           = ~bus.src_empty[cur_chan];
        bus.out_data            = bus.src_data[{cur_chan, 5'd0} +: 32];
        hs                      = bus.out_valid & bus.out_ready;
        bus.src_rd_en[cur_chan] = hs;
        bus.out_last            = bus.out_valid && (wcnt == WW'(BURST_WORDS - 2));
        if (hs && bus.out_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
